note_sequencer: RTL and testbench



---
 rtl/voice_pkg.sv | 19 +
 rtl/note_sequencer_if.sv | 25 ++
 rtl/note_sequencer_beat_timer.sv | 29 ++
 rtl/note_sequencer.sv | 109 ++++++++++
 tb/tb_note_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/voice_pkg.sv
// Shared constants and state encoding for the note sequencer and the voice/display logic.
package voice_pkg;

  localparam int unsigned NOTE_W = 6;
  localparam logic [NOTE_W-1:0] REST_NOTE = 6'd63;

  localparam int unsigned DEF_CNT_W   = 24;
  localparam int unsigned DEF_TICKS_0 = 12_500_000;
  localparam int unsigned DEF_TICKS_1 = 6_250_000;
  localparam int unsigned DEF_TICKS_2 = 3_125_000;
  localparam int unsigned DEF_TICKS_3 = 1_562_500;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the board control logic and the note sequencer.
interface note_sequencer_if;
  import voice_pkg::*;

  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [NOTE_W-1:0] song_len;
  logic [1:0]        tempo_sel;
  logic [NOTE_W-1:0] note;
  logic              playing;
  logic              beat_tick;
  logic              song_done;

  modport master (
    output start, stop, pause, loop_en, song_len, tempo_sel,
    input  note, playing, beat_tick, song_done
  );

  modport slave (
    input  start, stop, pause, loop_en, song_len, tempo_sel,
    output note, playing, beat_tick, song_done
  );
endinterface

// File: rtl/note_sequencer_beat_timer.sv
// Beat counter: counts enabled cycles and flags the last cycle of each beat period.
module beat_timer #(
    parameter int unsigned CNT_W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           enable,
    input  logic [CNT_W:0] period,
    output logic           wrap
);
    localparam int unsigned PER_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wrap  = enable && !clear && ({1'b0, cnt_q} == period - PER_W'(1));
        cnt_d = cnt_q;
        if (clear || wrap)
            cnt_d = '0;
        else if (enable)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/note_sequencer.sv
// Tempo-driven note sequencer: steps the shared note index through a song with
// start/stop/pause/loop control and emits beat and end-of-song pulses.
module note_sequencer
    import voice_pkg::*;
#(
    parameter int unsigned TICKS_0 = DEF_TICKS_0,
    parameter int unsigned TICKS_1 = DEF_TICKS_1,
    parameter int unsigned TICKS_2 = DEF_TICKS_2,
    parameter int unsigned TICKS_3 = DEF_TICKS_3,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input logic                CLOCK_50,
    input logic                reset,
    note_sequencer_if.slave    bus
);
    localparam int unsigned PER_W = CNT_W + 1;

    seq_state_e        state_q, state_d;
    logic [NOTE_W-1:0] index_q, index_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              playing_q, playing_d;
    logic              beat_tick_q, beat_tick_d;
    logic              song_done_q, song_done_d;

    logic timer_clear, timer_enable, wrap;

    // The cycle that enters pause is not counted, but the cycle that leaves it is,
    // so every note still spends exactly `period` counted cycles on the outputs.
    assign timer_clear  = bus.stop || bus.start || (state_q == IDLE);
    assign timer_enable = (state_q != IDLE) && !bus.pause;

    beat_timer #(.CNT_W(CNT_W)) u_beat_timer (
        .clk    (CLOCK_50),
        .rst    (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .period (period_q),
        .wrap   (wrap)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        period_d    = period_q;
        beat_tick_d = 1'b0;
        song_done_d = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            index_d = '0;
        end else if (bus.start) begin
            state_d = PLAY;
            index_d = '0;
            case (bus.tempo_sel)
                2'd0:    period_d = PER_W'(TICKS_0);
                2'd1:    period_d = PER_W'(TICKS_1);
                2'd2:    period_d = PER_W'(TICKS_2);
                default: period_d = PER_W'(TICKS_3);
            endcase
        end else if (state_q != IDLE) begin
            if (bus.pause) begin
                state_d = PAUSED;
            end else begin
                state_d = PLAY;
                if (wrap) begin
                    beat_tick_d = 1'b1;
                    if (index_q < bus.song_len) begin
                        index_d = index_q + NOTE_W'(1);
                    end else if (bus.loop_en) begin
                        index_d = '0;
                    end else begin
                        state_d     = IDLE;
                        index_d     = '0;
                        song_done_d = 1'b1;
                    end
                end
            end
        end

        note_d    = (state_d == PLAY) ? index_d : REST_NOTE;
        playing_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            index_q     <= '0;
            period_q    <= PER_W'(TICKS_0);
            note_q      <= REST_NOTE;
            playing_q   <= 1'b0;
            beat_tick_q <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            period_q    <= period_d;
            note_q      <= note_d;
            playing_q   <= playing_d;
            beat_tick_q <= beat_tick_d;
            song_done_q <= song_done_d;
        end
    end

    assign bus.note      = note_q;
    assign bus.playing   = playing_q;
    assign bus.beat_tick = beat_tick_q;
    assign bus.song_done = song_done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed table-driven bench for note_sequencer with short beat periods (4,3,2,1).
module tb_note_sequencer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    note_sequencer_if bus ();

    note_sequencer #(
        .TICKS_0(4), .TICKS_1(3), .TICKS_2(2), .TICKS_3(1), .CNT_W(24)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st, sp, pa, lp;
        logic [5:0] len;
        logic [1:0] ts;
        logic [5:0] en;
        logic       ep, et, ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, sp, pa, lp, input logic [5:0] len,
                       input logic [1:0] ts, input logic [5:0] en,
                       input logic ep, et, ed);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.lp = lp; v.len = len; v.ts = ts;
        v.en = en; v.ep = ep; v.et = et; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [5:0] got,
                       input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", nm, row, got, want);
        end
    endtask

    // Outputs seen this cycle are checked, then this cycle's inputs are driven
    // so they are sampled at the next rising edge.
    task automatic cyc(input string nm, input int row, input vec_t v);
        chk({nm, ".note"},      row, bus.note,              v.en);
        chk({nm, ".playing"},   row, {5'd0, bus.playing},   {5'd0, v.ep});
        chk({nm, ".beat_tick"}, row, {5'd0, bus.beat_tick}, {5'd0, v.et});
        chk({nm, ".song_done"}, row, {5'd0, bus.song_done}, {5'd0, v.ed});
        bus.start     = v.st;
        bus.stop      = v.sp;
        bus.pause     = v.pa;
        bus.loop_en   = v.lp;
        bus.song_len  = v.len;
        bus.tempo_sel = v.ts;
        @(negedge clk);
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) cyc(nm, i, tbl[i]);
        tbl.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0;
        bus.song_len = 6'd0; bus.tempo_sel = 2'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset.note",      i, bus.note,              6'd63);
            chk("reset.playing",   i, {5'd0, bus.playing},   6'd0);
            chk("reset.beat_tick", i, {5'd0, bus.beat_tick}, 6'd0);
            chk("reset.song_done", i, {5'd0, bus.song_done}, 6'd0);
        end
        rst = 1'b0;

        // Three notes of 4 cycles each, then natural end.
        add(1,0,0,0,2,0, 63,0,0,0);
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < 4; k++)
                add(0,0,0,0,2,0, 6'(n),1,(n > 0 && k == 0),0);
        add(0,0,0,0,2,0, 63,0,1,1);
        add(0,0,0,0,2,0, 63,0,0,0);
        run_tbl("play_once");

        // Period 1 with looping: index advances every clock, tick stays high.
        add(1,0,0,1,2,3, 63,0,0,0);
        for (int k = 0; k < 9; k++)
            add(0,0,0,1,2,3, 6'(k % 3),1,(k > 0),0);
        add(0,1,0,1,2,3, 0,1,1,0);
        add(0,0,0,1,2,3, 63,0,0,0);
        run_tbl("loop_fast");

        // Pause mid-note, stop+start together, then restart mid-song.
        add(1,0,0,0,2,0, 63,0,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,2,0, 0,1,0,0);
        add(0,0,0,0,2,0, 1,1,1,0);
        add(0,0,1,0,2,0, 1,1,0,0);
        for (int k = 0; k < 4; k++) add(0,0,1,0,2,0, 63,1,0,0);
        add(0,0,0,0,2,0, 63,1,0,0);
        add(0,0,0,0,2,0, 1,1,0,0);
        add(0,0,0,0,2,0, 1,1,0,0);
        add(1,1,0,0,2,0, 2,1,1,0);
        add(1,0,0,0,2,0, 63,0,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,2,0, 0,1,0,0);
        add(1,0,0,0,2,0, 1,1,1,0);
        for (int k = 0; k < 4; k++) add(0,0,0,0,2,0, 0,1,0,0);
        add(0,1,0,0,2,0, 1,1,1,0);
        add(0,0,0,0,2,0, 63,0,0,0);
        run_tbl("pause_stop");

        // Single-note song, no loop.
        add(1,0,0,0,0,1, 63,0,0,0);
        for (int k = 0; k < 3; k++) add(0,0,0,0,0,1, 0,1,0,0);
        add(0,0,0,0,0,1, 63,0,1,1);
        add(0,0,0,0,0,1, 63,0,0,0);
        run_tbl("single");

        // Hand sequence: song_len lowered below the current index ends at the next beat.
        begin
            vec_t v;
            v = '{st:1, sp:0, pa:0, lp:0, len:5, ts:3, en:63, ep:0, et:0, ed:0}; cyc("shrink", 0, v);
            v = '{st:0, sp:0, pa:0, lp:0, len:5, ts:3, en:0,  ep:1, et:0, ed:0}; cyc("shrink", 1, v);
            v = '{st:0, sp:0, pa:0, lp:0, len:5, ts:3, en:1,  ep:1, et:1, ed:0}; cyc("shrink", 2, v);
            v = '{st:0, sp:0, pa:0, lp:0, len:1, ts:3, en:2,  ep:1, et:1, ed:0}; cyc("shrink", 3, v);
            v = '{st:0, sp:0, pa:0, lp:0, len:1, ts:3, en:63, ep:0, et:1, ed:1}; cyc("shrink", 4, v);
            v = '{st:0, sp:0, pa:0, lp:0, len:1, ts:3, en:63, ep:0, et:0, ed:0}; cyc("shrink", 5, v);

            // Hand sequence: looping single note; tempo change after start is ignored.
            v = '{st:1, sp:0, pa:0, lp:1, len:0, ts:1, en:63, ep:0, et:0, ed:0}; cyc("latch", 0, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:0, ed:0}; cyc("latch", 1, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:0, ed:0}; cyc("latch", 2, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:0, ed:0}; cyc("latch", 3, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:1, ed:0}; cyc("latch", 4, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:0, ed:0}; cyc("latch", 5, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:0, ed:0}; cyc("latch", 6, v);
            v = '{st:0, sp:1, pa:0, lp:1, len:0, ts:3, en:0,  ep:1, et:1, ed:0}; cyc("latch", 7, v);
            v = '{st:0, sp:0, pa:0, lp:1, len:0, ts:3, en:63, ep:0, et:0, ed:0}; cyc("latch", 8, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
